// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared widths and output-stage state type for the 8-to-3 event encoder
package enc_pkg;

  localparam int ENC_W = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } enc_state_t;

endpackage

// File: rtl/encode_4_2.sv
// rtl/encode_4_2.sv - combinational 4-to-2 priority encoder with request-present flag
module encode_4_2 #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [3:0] i_req,
  output logic [1:0] o_idx,
  output logic       o_any
);

  always_comb begin
    o_idx = 2'd0;
    o_any = |i_req;
    if (HIGH_FIRST) begin
      if (i_req[3])      o_idx = 2'd3;
      else if (i_req[2]) o_idx = 2'd2;
      else if (i_req[1]) o_idx = 2'd1;
      else               o_idx = 2'd0;
    end else begin
      if (i_req[0])      o_idx = 2'd0;
      else if (i_req[1]) o_idx = 2'd1;
      else if (i_req[2]) o_idx = 2'd2;
      else               o_idx = 2'd3;
    end
  end

endmodule

// File: rtl/encode_8_3_sync.sv
// rtl/encode_8_3_sync.sv - registered 8-to-3 priority event encoder with valid/ready output
// Optional sticky overflow flag under ENC_OVERFLOW_EN.
module encode_8_3_sync
  import enc_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             E,
  input  logic [ENC_W-1:0] In,
  output logic [IDX_W-1:0] Out,
  output logic             valid,
  input  logic             ready,
`ifdef ENC_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic [ENC_W-1:0] pending
);

  enc_state_t       r_state;
  enc_state_t       w_state_nxt;
  logic [ENC_W-1:0] r_pending;
  logic [IDX_W-1:0] r_out;
  logic             w_load;
  logic [ENC_W-1:0] w_clr;
  logic [ENC_W-1:0] w_set;
  logic [1:0]       w_hi_idx;
  logic [1:0]       w_lo_idx;
  logic             w_hi_any;
  logic             w_lo_any;
  logic             w_sel_hi;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;

  // Only the pending register feeds the encoders, so a fresh In bit is never presented early.
  encode_4_2 #(.HIGH_FIRST(HIGH_FIRST)) u_enc_hi (
    .i_req (r_pending[7:4]),
    .o_idx (w_hi_idx),
    .o_any (w_hi_any)
  );

  encode_4_2 #(.HIGH_FIRST(HIGH_FIRST)) u_enc_lo (
    .i_req (r_pending[3:0]),
    .o_idx (w_lo_idx),
    .o_any (w_lo_any)
  );

  assign w_sel_hi = HIGH_FIRST ? w_hi_any : ~w_lo_any;
  assign w_idx    = {w_sel_hi, (w_sel_hi ? w_hi_idx : w_lo_idx)};
  assign w_any    = w_hi_any | w_lo_any;
  assign w_set    = E ? In : '0;
  assign w_clr    = w_load ? (ENC_W'(1) << w_idx) : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_HOLD;
          w_load      = 1'b1;
        end
      end
      ST_HOLD: begin
        if (ready) begin
          if (w_any) w_load = 1'b1;
          else       w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Set wins over clear: a request re-asserted on its load edge stays pending.
  always_ff @(posedge clka) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_out     <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_load) r_out <= w_idx;
    end
  end

`ifdef ENC_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge clka) begin
    if (rst) r_overflow <= 1'b0;
    else if (|(w_set & r_pending & ~w_clr)) r_overflow <= 1'b1;
  end

  assign overflow = r_overflow;
`endif

  assign Out     = r_out;
  assign valid   = (r_state == ST_HOLD);
  assign pending = r_pending;

endmodule

// File: tb/tb_encode_8_3_sync.sv
// tb/tb_encode_8_3_sync.sv - scoreboard bench driving both priority orders in parallel
module tb_encode_8_3_sync;

  logic       clka = 1'b0;
  logic       rst;
  logic       E;
  logic [7:0] In;
  logic       ready;
  logic [2:0] out_h, out_l;
  logic       valid_h, valid_l;
  logic [7:0] pend_h, pend_l;
`ifdef ENC_OVERFLOW_EN
  logic       ovf_h, ovf_l;
`endif

  int total = 0;
  int bad   = 0;
  int q_h[$];
  int q_l[$];

  always #5 clka = ~clka;

  encode_8_3_sync #(.HIGH_FIRST(1'b1)) dut_h (
    .clka(clka), .rst(rst), .E(E), .In(In), .Out(out_h), .valid(valid_h), .ready(ready),
`ifdef ENC_OVERFLOW_EN
    .overflow(ovf_h),
`endif
    .pending(pend_h)
  );

  encode_8_3_sync #(.HIGH_FIRST(1'b0)) dut_l (
    .clka(clka), .rst(rst), .E(E), .In(In), .Out(out_l), .valid(valid_l), .ready(ready),
`ifdef ENC_OVERFLOW_EN
    .overflow(ovf_l),
`endif
    .pending(pend_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  // A transfer happens on the next edge whenever valid and ready are both high now.
  always @(negedge clka) begin
    if (!rst && ready && valid_h) begin
      if (q_h.size() == 0) check("sb_h_extra", 0, 1);
      else check("sb_h_out", out_h, q_h.pop_front());
    end
    if (!rst && ready && valid_l) begin
      if (q_l.size() == 0) check("sb_l_extra", 0, 1);
      else check("sb_l_out", out_l, q_l.pop_front());
    end
  end

  initial begin
    rst = 1'b1; E = 1'b1; In = 8'hFF; ready = 1'b0;
    tick();
    check("rst_pend_h", pend_h, 8'h00);
    check("rst_valid_h", valid_h, 0);
    check("rst_out_h", out_h, 0);
    check("rst_pend_l", pend_l, 8'h00);
    rst = 1'b0;
    tick();
    check("rel_pend_h", pend_h, 8'hFF);
    check("rel_pend_l", pend_l, 8'hFF);

    E = 1'b0;
    tick();
    check("gate_valid_h", valid_h, 1);
    check("gate_out_h", out_h, 7);
    check("gate_out_l", out_l, 0);
    check("gate_pend_h", pend_h, 8'h7F);
    check("gate_pend_l", pend_l, 8'hFE);
    rst = 1'b1;
    tick();
    check("midrst_valid_h", valid_h, 0);
    check("midrst_pend_h", pend_h, 8'h00);
    check("midrst_valid_l", valid_l, 0);
    check("midrst_pend_l", pend_l, 8'h00);
    rst = 1'b0; E = 1'b1; In = 8'h00;
    tick();

    ready = 1'b1; In = 8'h20;
    q_h.push_back(5); q_l.push_back(5);
    tick();
    In = 8'h00;
    check("single_early_valid", valid_h, 0);
    tick();
    check("single_valid", valid_h, 1);
    tick();
    check("single_idle", valid_h, 0);
    check("single_pend", pend_h, 8'h00);

    In = 8'h91;
    q_h.push_back(7); q_h.push_back(4); q_h.push_back(0);
    q_l.push_back(0); q_l.push_back(4); q_l.push_back(7);
    tick();
    In = 8'h00;
    repeat (4) tick();
    check("multi_idle_h", valid_h, 0);
    check("multi_idle_l", valid_l, 0);

    ready = 1'b0; In = 8'h0C;
    q_h.push_back(3); q_h.push_back(2);
    q_l.push_back(2); q_l.push_back(3);
    tick();
    In = 8'h00;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_h", out_h, 3);
      check("bp_out_l", out_l, 2);
      check("bp_valid_h", valid_h, 1);
    end
    ready = 1'b1;
    repeat (3) tick();
    check("bp_idle_h", valid_h, 0);

    In = 8'h40;
    q_h.push_back(6); q_h.push_back(6);
    q_l.push_back(6); q_l.push_back(6);
    tick();
    tick();
    check("coll_pend_h", pend_h, 8'h40);
    check("coll_out_h", out_h, 6);
    In = 8'h00;
    repeat (3) tick();
    check("coll_idle_l", valid_l, 0);
`ifdef ENC_OVERFLOW_EN
    check("coll_ovf_h", ovf_h, 0);
    check("coll_ovf_l", ovf_l, 0);
    ready = 1'b0; In = 8'h41;
    tick();
    In = 8'h00;
    tick();
    check("ovf_pre_h", ovf_h, 0);
    In = 8'h41;
    tick();
    In = 8'h00;
    check("ovf_set_h", ovf_h, 1);
    check("ovf_set_l", ovf_l, 1);
    tick();
    check("ovf_sticky_h", ovf_h, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ovf_rst_h", ovf_h, 0);
    tick();
`endif

    check("sb_h_left", q_h.size(), 0);
    check("sb_l_left", q_l.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
